f2c_dma_writer: RTL and testbench

FPGA-side producer for the FPGA->CPU (F2C) DMA ring. It takes a 64-bit stream from the application, cuts it into fixed-size memory-write bursts and addresses each burst into the host's chunked circular buffer. After every completed chunk it posts the new write pointer into the host metrics buffer. It sits between the application data source and the TLP transmitter, and is controlled by the DMA_ENABLE, F2C_BASE, MTR_BASE and F2C_RDPTR registers.

---
 rtl/f2c_dma_writer.sv | 161 ++++++++++++++++
 tb/tb_f2c_dma_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f2c_dma_writer.sv
// FPGA->host DMA ring producer: slices a 64-bit stream into write bursts
// and posts the chunk write pointer to the host metrics buffer.
module f2c_dma_writer #(
  parameter int TLP_QWS    = 16,
  parameter int CHUNK_TLPS = 32,
  parameter int PTR_BITS   = 2
) (
  input  logic                pcieClk_in,
  input  logic                reset_in,
  input  logic                enable_in,
  input  logic [28:0]         f2cBase_in,
  input  logic [28:0]         mtrBase_in,
  input  logic [PTR_BITS-1:0] rdPtr_in,
  input  logic [63:0]         f2cData_in,
  input  logic                f2cValid_in,
  output logic                f2cReady_out,
  output logic                cmdValid_out,
  input  logic                cmdReady_in,
  output logic [28:0]         cmdAddr_out,
  output logic [9:0]          cmdDwCount_out,
  output logic [63:0]         txData_out,
  output logic                txValid_out,
  input  logic                txReady_in,
  output logic [PTR_BITS-1:0] wrPtr_out
);

  localparam int BEAT_W =
    (TLP_QWS > 1) ? $clog2(TLP_QWS) : 1;
  localparam int IDX_W =
    (CHUNK_TLPS > 1) ? $clog2(CHUNK_TLPS) : 1;
  localparam int CHUNK_QWS = CHUNK_TLPS * TLP_QWS;

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(TLP_QWS - 1);
  localparam logic [IDX_W-1:0] LAST_TLP =
    IDX_W'(CHUNK_TLPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    MHDR,
    MDATA
  } state_t;

  state_t              state;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [IDX_W-1:0]    tlp_idx;
  logic [BEAT_W-1:0]   beat;
  logic                cmd_valid;
  logic [28:0]         cmd_addr;
  logic [9:0]          cmd_dw;

  logic [PTR_BITS-1:0] wr_next;
  logic                space;
  logic [28:0]         hdr_addr;
  logic                beat_hs;

  // One ring slot always stays empty so full and empty differ.
  assign wr_next = wr_ptr + PTR_BITS'(1);
  assign space   = (wr_next != rdPtr_in);
  assign beat_hs = f2cValid_in && txReady_in;

  assign hdr_addr = f2cBase_in
                  + 29'(wr_ptr) * 29'(CHUNK_QWS)
                  + 29'(tlp_idx) * 29'(TLP_QWS);

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      tlp_idx   <= '0;
      beat      <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_dw    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_valid <= 1'b0;
          if (!enable_in) begin
            wr_ptr  <= '0;
            tlp_idx <= '0;
          end else if (space) begin
            state     <= HDR;
            cmd_valid <= 1'b1;
            cmd_addr  <= hdr_addr;
            cmd_dw    <= 10'(2 * TLP_QWS);
          end
        end
        HDR: begin
          if (cmdReady_in) begin
            state     <= DATA;
            cmd_valid <= 1'b0;
            beat      <= '0;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat <= beat + BEAT_W'(1);
            if (beat == LAST_BEAT) begin
              if (tlp_idx != LAST_TLP) begin
                tlp_idx <= tlp_idx + IDX_W'(1);
                state   <= IDLE;
              end else begin
                tlp_idx   <= '0;
                wr_ptr    <= wr_next;
                state     <= MHDR;
                cmd_valid <= 1'b1;
                cmd_addr  <= mtrBase_in;
                cmd_dw    <= 10'd1;
              end
            end
          end
        end
        MHDR: begin
          if (cmdReady_in) begin
            state     <= MDATA;
            cmd_valid <= 1'b0;
          end
        end
        MDATA: begin
          if (txReady_in) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  // Payload beats flow straight through; only the metrics DW is local.
  always_comb begin
    f2cReady_out = 1'b0;
    txValid_out  = 1'b0;
    txData_out   = '0;
    case (state)
      DATA: begin
        f2cReady_out = txReady_in;
        txValid_out  = f2cValid_in;
        txData_out   = f2cData_in;
      end
      MDATA: begin
        txValid_out = 1'b1;
        txData_out  = 64'(wr_ptr);
      end
      default: begin
        f2cReady_out = 1'b0;
      end
    endcase
  end

  assign cmdValid_out   = cmd_valid;
  assign cmdAddr_out    = cmd_addr;
  assign cmdDwCount_out = cmd_dw;
  assign wrPtr_out      = wr_ptr;

endmodule

// File: tb/tb_f2c_dma_writer.sv
// Bench for f2c_dma_writer: queue-based command/payload scoreboard
// fed by a chunk/TLP arithmetic model, with randomized handshakes.
module tb_f2c_dma_writer;

  localparam int TLP_QWS    = 16;
  localparam int CHUNK_TLPS = 32;
  localparam int PTR_BITS   = 2;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [28:0] f2c_base = 29'h100;
  logic [28:0] mtr_base = 29'h2000;
  logic [1:0]  rd_ptr = 2'd0;
  logic [63:0] f2c_data = '0;
  logic        f2c_valid = 1'b0;
  logic        f2c_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [28:0] cmd_addr;
  logic [9:0]  cmd_dw;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [1:0]  wr_ptr;

  f2c_dma_writer #(
    .TLP_QWS(TLP_QWS),
    .CHUNK_TLPS(CHUNK_TLPS),
    .PTR_BITS(PTR_BITS)
  ) dut (
    .pcieClk_in(clk),
    .reset_in(reset_in),
    .enable_in(enable_in),
    .f2cBase_in(f2c_base),
    .mtrBase_in(mtr_base),
    .rdPtr_in(rd_ptr),
    .f2cData_in(f2c_data),
    .f2cValid_in(f2c_valid),
    .f2cReady_out(f2c_ready),
    .cmdValid_out(cmd_valid),
    .cmdReady_in(cmd_ready),
    .cmdAddr_out(cmd_addr),
    .cmdDwCount_out(cmd_dw),
    .txData_out(tx_data),
    .txValid_out(tx_valid),
    .txReady_in(tx_ready),
    .wrPtr_out(wr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] addr;
    logic [9:0]  dw;
    logic [63:0] mval;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int src_cnt = 0;
  int mon_seq = 0;
  int cmd_cnt = 0;
  int beats = 0;
  int exp_beats = 0;
  logic [9:0]  cur_dw = '0;
  logic [63:0] cur_mval = '0;
  bit abandon = 1'b0;
  bit rnd = 1'b0;
  bit hold_v = 1'b0;
  logic [28:0] hold_addr = '0;
  logic [9:0]  hold_dw = '0;

  function automatic logic [63:0] seq64(input int n);
    return {32'(n) ^ 32'hA5A5_5A5A, 32'(n)};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: TLP number t lands in chunk t/CHUNK_TLPS of the ring.
  task automatic push_tlps(input logic [28:0] base,
                           input logic [28:0] mtr,
                           input int first,
                           input int n);
    exp_t e;
    int chunk;
    for (int t = first; t < first + n; t++) begin
      chunk  = (t / CHUNK_TLPS) % (1 << PTR_BITS);
      e.addr = base
             + 29'(chunk * CHUNK_TLPS * TLP_QWS)
             + 29'((t % CHUNK_TLPS) * TLP_QWS);
      e.dw   = 10'(2 * TLP_QWS);
      e.mval = '0;
      exp_q.push_back(e);
      if (t % CHUNK_TLPS == CHUNK_TLPS - 1) begin
        e.addr = mtr;
        e.dw   = 10'd1;
        e.mval = 64'((t / CHUNK_TLPS + 1) % (1 << PTR_BITS));
        exp_q.push_back(e);
      end
    end
  endtask

  // Source and backpressure driver.
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = f2c_valid && f2c_ready;
      @(posedge clk);
      #1;
      if (hs) src_cnt++;
      f2c_data = seq64(src_cnt);
      if (rnd) begin
        f2c_valid = ($urandom_range(0, 3) != 0);
        tx_ready  = ($urandom_range(0, 3) != 0);
        cmd_ready = ($urandom_range(0, 2) == 0);
      end else begin
        f2c_valid = 1'b1;
        tx_ready  = 1'b1;
        cmd_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each command handshake.
  always @(negedge clk) begin
    exp_t e;
    if (hold_v && cmd_valid) begin
      chk("cmd_addr_stable", 64'(cmd_addr), 64'(hold_addr));
      chk("cmd_dw_stable", 64'(cmd_dw), 64'(hold_dw));
    end
    hold_v    = cmd_valid && !cmd_ready;
    hold_addr = cmd_addr;
    hold_dw   = cmd_dw;
    if (cmd_valid && cmd_ready) begin
      if (!abandon)
        chk("beats_per_cmd", 64'(beats), 64'(exp_beats));
      abandon = 1'b0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got addr %h dw %0d want none",
                 cmd_addr, cmd_dw);
        cur_dw    = cmd_dw;
        cur_mval  = '0;
        exp_beats = (cmd_dw == 10'd1) ? 1 : TLP_QWS;
      end else begin
        e = exp_q.pop_front();
        chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
        chk("cmd_dw", 64'(cmd_dw), 64'(e.dw));
        cur_dw    = e.dw;
        cur_mval  = e.mval;
        exp_beats = (e.dw == 10'd1) ? 1 : TLP_QWS;
      end
      beats = 0;
      cmd_cnt++;
    end
    if (tx_valid && tx_ready) begin
      beats++;
      if (beats > exp_beats && !abandon) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got beat %0d want at most %0d",
                 beats, exp_beats);
      end else if (cur_dw == 10'd1) begin
        chk("metric_data", tx_data, cur_mval);
      end else begin
        chk("payload", tx_data, seq64(mon_seq));
      end
      if (cur_dw != 10'd1) mon_seq++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && beats == exp_beats)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: got timeout, %0d cmds pending, want drained",
               name, exp_q.size());
    end
  endtask

  task automatic wait_for(input string name, input int c,
                          input int b, input int budget);
    int n = 0;
    while (!(cmd_cnt >= c && beats >= b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: got timeout at cmd %0d beat %0d want %0d/%0d",
               name, cmd_cnt, beats, c, b);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_f2c_ready"}, 64'(f2c_ready), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_cmd_dw"}, 64'(cmd_dw), 64'd0);
    chk({tag, "_tx_data"}, tx_data, 64'd0);
    chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'd0);
  endtask

  initial begin
    int c0;
    repeat (3) step();
    @(negedge clk);
    check_reset_outs("por");
    step();
    reset_in = 1'b0;

    // Three chunks fill the ring, then a read-pointer bump frees one.
    push_tlps(29'h100, 29'h2000, 0, 3 * CHUNK_TLPS);
    enable_in = 1'b1;
    wait_drain("full_ring_drain", 6000);
    idle(100);
    chk("full_ring_wr_ptr", 64'(wr_ptr), 64'd3);
    chk("full_ring_stall", 64'(cmd_valid), 64'd0);
    push_tlps(29'h100, 29'h2000, 3 * CHUNK_TLPS, CHUNK_TLPS);
    step();
    rd_ptr = 2'd1;
    wait_drain("resume_drain", 3000);
    idle(50);
    chk("resume_wr_ptr", 64'(wr_ptr), 64'd0);

    // Enable dropped partway through TLP 3.
    step();
    enable_in = 1'b0;
    rd_ptr = 2'd2;
    repeat (3) step();
    c0 = cmd_cnt;
    push_tlps(29'h100, 29'h2000, 0, 4);
    enable_in = 1'b1;
    wait_for("disable_point", c0 + 4, 5, 500);
    step();
    enable_in = 1'b0;
    wait_drain("disable_drain", 500);
    idle(50);
    chk("disable_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("disable_no_cmd", 64'(cmd_valid), 64'd0);

    // Re-enable, then reset in the middle of the first burst.
    c0 = cmd_cnt;
    push_tlps(29'h100, 29'h2000, 0, 3);
    step();
    enable_in = 1'b1;
    wait_for("reset_point", c0 + 1, 7, 500);
    abandon = 1'b1;
    step();
    reset_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outs("mid_reset");
    exp_q.delete();
    enable_in = 1'b0;
    step();
    step();
    reset_in = 1'b0;

    // Base near the top of the 29-bit space, random handshakes.
    f2c_base = 29'h1FFF_FFF0;
    mtr_base = 29'($urandom);
    rd_ptr = 2'd2;
    rnd = 1'b1;
    push_tlps(f2c_base, mtr_base, 0, CHUNK_TLPS);
    step();
    enable_in = 1'b1;
    wait_drain("random_drain", 20000);
    idle(50);
    chk("random_wr_ptr", 64'(wr_ptr), 64'd1);
    chk("random_stall", 64'(cmd_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
